fifo_flex: RTL

- Parametrised successor to the team's single-clock block-RAM FIFO. Stores words in sync_dual_port_ram.
- Adds:
  - an occupancy count
  - programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - a synchronous flush
  - a selectable first-word-fall-through (FWFT) read mode
  - correct simultaneous read/write at the empty and full boundaries
- Used as the general buffering element between streaming datapath stages.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_fwft_stage.sv | 61 ++++++
 rtl/sync_dual_port_ram.sv | 27 ++
 rtl/fifo_flex.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the flexible FIFO: FWFT output-stage state encoding
// and the occupancy-count width helper.
package fifo_pkg;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_PREFETCH = 2'd1;
    localparam logic [1:0] ST_VALID    = 2'd2;

    // A count must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_fwft_stage.sv
// First-word-fall-through output stage controller. The RAM's held read
// register acts as the stage data register; this block decides when to fetch.
module fifo_fwft_stage
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic ram_empty,
    input  logic pop,
    output logic fetch,
    output logic valid
);

    logic [1:0] state;
    logic [1:0] state_next;

    always_comb begin
        fetch      = 1'b0;
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (!ram_empty) begin
                    fetch      = 1'b1;
                    state_next = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                state_next = ST_VALID;
            end
            ST_VALID: begin
                // Refill on the same edge as the pop so back-to-back pops see no bubble.
                if (pop) begin
                    if (!ram_empty) begin
                        fetch = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (clear) begin
            fetch      = 1'b0;
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign valid = (state == ST_VALID);

endmodule

// File: rtl/sync_dual_port_ram.sv
// Simple dual-port block RAM: one synchronous write port, one registered read
// port whose output holds while read_en is low.
module sync_dual_port_ram #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_en,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDRESS_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_address] <= write_data;
        end
        if (read_en) begin
            read_data <= mem[read_address];
        end
    end

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO over block RAM with occupancy count,
// threshold flags, sticky error flags, synchronous flush and optional FWFT.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH      = 4,
    parameter int DATA_WIDTH         = 8,
    parameter int ALMOST_FULL_LEVEL  = (2 ** ADDRESS_WIDTH) - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int FWFT               = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    read,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_WIDTH:0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int CW    = count_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_LEVEL = CW'(ALMOST_EMPTY_LEVEL);

    logic [ADDRESS_WIDTH:0] wr_ptr;
    logic [ADDRESS_WIDTH:0] rd_ptr;
    logic [ADDRESS_WIDTH:0] wr_ptr_next;
    logic [ADDRESS_WIDTH:0] rd_ptr_next;
    logic [CW-1:0]          count_next;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   fetch;

    assign wr_acc = write & ~full & ~clear;
    assign rd_acc = read & ~empty & ~clear;

    assign wr_ptr_next = wr_ptr + {{ADDRESS_WIDTH{1'b0}}, wr_acc};
    assign rd_ptr_next = rd_ptr + {{ADDRESS_WIDTH{1'b0}}, fetch};

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            almost_full  <= (count_next >= AF_LEVEL);
            almost_empty <= (count_next <= AE_LEVEL);
            if (write && full) begin
                overflow <= 1'b1;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    sync_dual_port_ram #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk           (clk),
        .write_en      (wr_acc),
        .write_address (wr_ptr[ADDRESS_WIDTH-1:0]),
        .write_data    (write_data),
        .read_en       (fetch),
        .read_address  (rd_ptr[ADDRESS_WIDTH-1:0]),
        .read_data     (read_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            logic ram_empty;
            logic stage_valid;

            // In FWFT mode the storage pointers exclude the word held in the output stage.
            assign ram_empty = (wr_ptr == rd_ptr);

            fifo_fwft_stage u_stage (
                .clk       (clk),
                .reset     (reset),
                .clear     (clear),
                .ram_empty (ram_empty),
                .pop       (rd_acc),
                .fetch     (fetch),
                .valid     (stage_valid)
            );

            assign empty      = ~stage_valid;
            assign read_valid = stage_valid;
        end else begin : g_std
            assign fetch = rd_acc;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    empty      <= 1'b1;
                    read_valid <= 1'b0;
                end else if (clear) begin
                    empty      <= 1'b1;
                    read_valid <= 1'b0;
                end else begin
                    empty      <= (wr_ptr_next == rd_ptr_next);
                    read_valid <= rd_acc;
                end
            end
        end
    endgenerate

endmodule
